// File: rtl/dimension_swap_if.sv
// Bus bundle for dimension_swap: source matrix in, combinational and registered transposes out.
// load is a plain capture strobe: no valid/ready handshake, the slave never stalls and samples it every rising edge.
interface dimension_swap_if #(
  parameter int U = 4,
  parameter int P = 1
);
  logic           load;
  logic [P-1:0]   in       [U];
  logic [U-1:0]   out_comb [P];
  logic [U-1:0]   out      [P];

  modport master (
    output load,
    output in,
    input  out_comb,
    input  out
  );

  modport slave (
    input  load,
    input  in,
    output out_comb,
    output out
  );
endinterface

// File: rtl/dimension_swap.sv
// Matrix transpose: U words of P bits become P words of U bits, available combinationally
// and as a load-enabled register built from per-bit 2:1 select cells.
module dimension_swap_mux2 (
  input  logic [1:0] in,
  input  logic       sel,
  output logic       y
);
  assign y = sel ? in[1] : in[0];
endmodule

module dimension_swap #(
  parameter int INPUT_UNPACKED_SIZE = 4,
  parameter int INPUT_PACKED_SIZE   = 1
) (
  input  logic            clk,
  input  logic            reset,
  dimension_swap_if.slave bus
);
  localparam int U = INPUT_UNPACKED_SIZE;
  localparam int P = INPUT_PACKED_SIZE;

  logic [P-1:0][U-1:0] comb_t;
  logic [P-1:0][U-1:0] sel_y;
  logic [P-1:0][U-1:0] out_d;
  logic [P-1:0][U-1:0] out_q;

  for (genvar gj = 0; gj < P; gj++) begin : g_word
    for (genvar gi = 0; gi < U; gi++) begin : g_bit
      // Pure wiring; the cell holds the register bit unless load picks the new transpose bit.
      assign comb_t[gj][gi] = bus.in[gi][gj];

      dimension_swap_mux2 u_cell (
        .in  ({comb_t[gj][gi], out_q[gj][gi]}),
        .sel (bus.load),
        .y   (sel_y[gj][gi])
      );
    end
    assign bus.out_comb[gj] = comb_t[gj];
    assign bus.out[gj]      = out_q[gj];
  end

  always_comb begin
    out_d = sel_y;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end
endmodule

// File: tb/tb_dimension_swap.sv
// Directed bench for dimension_swap: a 4x3 instance, a default 4x1 instance and a bare select cell.
module tb_dimension_swap;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [11:0] exp_q  [$];
  logic [11:0] exp1_q [$];
  logic [11:0] exp_v;

  dimension_swap_if #(.U(4), .P(3)) bus  ();
  dimension_swap_if #(.U(4), .P(1)) bus1 ();

  dimension_swap #(.INPUT_UNPACKED_SIZE(4), .INPUT_PACKED_SIZE(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  dimension_swap dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  logic [1:0] m_in;
  logic       m_sel;
  logic       m_y;

  dimension_swap_mux2 u_mux (
    .in  (m_in),
    .sel (m_sel),
    .y   (m_y)
  );

  logic [11:0] comb_flat;
  logic [11:0] out_flat;
  logic [3:0]  comb1_flat;
  logic [3:0]  out1_flat;

  assign comb_flat  = {bus.out_comb[2], bus.out_comb[1], bus.out_comb[0]};
  assign out_flat   = {bus.out[2], bus.out[1], bus.out[0]};
  assign comb1_flat = bus1.out_comb[0];
  assign out1_flat  = bus1.out[0];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: word j bit i of the result is bit j of source word i
  function automatic logic [11:0] model_t(input logic [2:0] a0, input logic [2:0] a1,
                                           input logic [2:0] a2, input logic [2:0] a3);
    logic [2:0]  a [4];
    logic [11:0] r;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    r = '0;
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 4; i++)
        r[j*4+i] = a[i][j];
    return r;
  endfunction

  task automatic drive_in(input logic [2:0] a0, input logic [2:0] a1,
                          input logic [2:0] a2, input logic [2:0] a3);
    bus.in[0] = a0; bus.in[1] = a1; bus.in[2] = a2; bus.in[3] = a3;
  endtask

  task automatic pop_check(input string tag, input logic [11:0] obs);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      total--;
      check(tag, obs, exp_v);
    end
  endtask

  task automatic pop_check1(input string tag, input logic [11:0] obs);
    total++;
    if (exp1_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      exp_v = exp1_q.pop_front();
      total--;
      check(tag, obs, exp_v);
    end
  endtask

  initial begin
    logic [2:0] r [4];
    logic [3:0] p4;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.load  = 1'b0;
    bus1.load = 1'b0;
    drive_in(3'b000, 3'b000, 3'b000, 3'b000);
    bus1.in[0] = 1'b0; bus1.in[1] = 1'b0; bus1.in[2] = 1'b0; bus1.in[3] = 1'b0;
    m_in = 2'b00; m_sel = 1'b0;
    step();
    check("reset_out", out_flat, 12'h000);
    check("reset_out1", {8'h00, out1_flat}, 12'h000);

    // fixed 4x3 example: combinational result in the same cycle
    reset = 1'b0;
    drive_in(3'b000, 3'b001, 3'b100, 3'b111);
    #1;
    check("comb_example", comb_flat, 12'b1100_1000_1010);
    check("comb_model", comb_flat, model_t(3'b000, 3'b001, 3'b100, 3'b111));
    check("idle_after_reset", out_flat, 12'h000);

    reset = 1'b1;
    step();
    check("reset_edge", out_flat, 12'h000);
    reset = 1'b0;
    bus.load = 1'b1;
    exp_q.push_back(12'b1100_1000_1010);
    step();
    pop_check("load_example", out_flat);

    // hold with new input: register frozen, comb follows
    bus.load = 1'b0;
    drive_in(3'b111, 3'b111, 3'b111, 3'b111);
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_out", out_flat, 12'b1100_1000_1010);
      check("hold_comb", comb_flat, 12'hfff);
    end

    // reset wins over load; comb unaffected by reset
    reset = 1'b1;
    bus.load = 1'b1;
    drive_in(3'b101, 3'b010, 3'b110, 3'b011);
    #1;
    check("comb_during_reset", comb_flat, model_t(3'b101, 3'b010, 3'b110, 3'b011));
    step();
    check("reset_over_load", out_flat, 12'h000);
    reset = 1'b0;
    bus.load = 1'b0;
    step();
    check("stay_zero_no_load", out_flat, 12'h000);

    // random back-to-back loads through the scoreboard
    bus.load = 1'b1;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 4; i++) r[i] = 3'($urandom_range(0, 7));
      drive_in(r[0], r[1], r[2], r[3]);
      exp_q.push_back(model_t(r[0], r[1], r[2], r[3]));
      step();
      pop_check("rand_load", out_flat);
    end

    // reset mid-sequence, then the next load captures normally
    reset = 1'b1;
    step();
    check("reset_mid_seq", out_flat, 12'h000);
    reset = 1'b0;
    drive_in(3'b011, 3'b100, 3'b001, 3'b110);
    exp_q.push_back(model_t(3'b011, 3'b100, 3'b001, 3'b110));
    step();
    pop_check("load_after_reset", out_flat);
    bus.load = 1'b0;

    // default 4x1 instance: sweep all 16 patterns with load held high
    bus1.load = 1'b1;
    for (int p = 0; p < 16; p++) begin
      p4 = 4'(p);
      bus1.in[0] = p4[0]; bus1.in[1] = p4[1]; bus1.in[2] = p4[2]; bus1.in[3] = p4[3];
      #1;
      check("sweep_comb", {8'h00, comb1_flat}, {8'h00, p4});
      exp1_q.push_back({8'h00, p4});
      step();
      pop_check1("sweep_out", {8'h00, out1_flat});
    end
    bus1.load = 1'b0;

    // bare select cell, all 8 combinations
    for (int c = 0; c < 8; c++) begin
      m_in  = 2'(c & 3);
      m_sel = 1'((c >> 2) & 1);
      #1;
      check("mux_cell", {11'h000, m_y}, {11'h000, m_in[m_sel]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
